// File: rtl/npu_act_wr_arbiter_pkg.sv
// Shared constants and small helpers for the activation write-back arbiter.
// Neuron count and address width match the values npu_layer is built with.
package npu_act_wr_arbiter_pkg;

   localparam int LOG2_ACT_ADDR_WIDTH = 10;
   localparam int NPU_NUM_NEURONS     = 32;
   localparam int RR_IDX_W            = 5;
   localparam int WR_COUNT_W          = 16;

   typedef logic [NPU_NUM_NEURONS-1:0] ch_vec_t;
   typedef logic [RR_IDX_W-1:0]        ch_idx_t;
   typedef logic [WR_COUNT_W-1:0]      wr_count_t;

   localparam wr_count_t WR_COUNT_MAX = '1;

   // Round-robin successor; the index width makes 31 wrap to 0.
   function automatic ch_idx_t next_ptr(input ch_idx_t idx);
      return idx + ch_idx_t'(1);
   endfunction

endpackage

// File: rtl/npu_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Zero latency; no backpressure of its own (caller gates the grant).
module npu_rr_arbiter
   import npu_act_wr_arbiter_pkg::*;
(
   input  logic [NPU_NUM_NEURONS-1:0] req,
   input  logic [RR_IDX_W-1:0]        ptr,
   output logic [NPU_NUM_NEURONS-1:0] gnt,
   output logic [RR_IDX_W-1:0]        gnt_idx,
   output logic                       gnt_vld
);

   ch_vec_t                      at_or_after;
   logic [2*NPU_NUM_NEURONS-1:0] dbl_req;

   always_comb begin
      at_or_after = ~((ch_vec_t'(1) << ptr) - ch_vec_t'(1));
      // Lower half holds requests at/after ptr, upper half the unmasked copy
      // so the scan naturally wraps past channel 31.
      dbl_req = {req, req & at_or_after};
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int i = 2*NPU_NUM_NEURONS-1; i >= 0; i--) begin
         if (dbl_req[i]) begin
            gnt_vld = 1'b1;
            gnt_idx = ch_idx_t'(i);
         end
      end
      gnt = gnt_vld ? (ch_vec_t'(1) << gnt_idx) : '0;
   end

endmodule

// File: rtl/npu_act_wr_arbiter.sv
// Serialises neuron activation write-backs onto one RAM write port, round-robin.
// One-cycle request-to-write latency; act_mem_ready=0 withholds grants, requests stay held.
module npu_act_wr_arbiter
   import npu_act_wr_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = LOG2_ACT_ADDR_WIDTH,
   parameter int NUM_CH     = NPU_NUM_NEURONS
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH-1:0]            hw_mem_wr,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] hw_mem_wr_addr,
   input  logic [NUM_CH*DATA_WIDTH-1:0] hw_mem_wr_data,
   output logic [NUM_CH-1:0]            hw_mem_wr_ack_p,
   input  logic                         act_mem_ready,
   output logic                         act_mem_we,
   output logic [ADDR_WIDTH-1:0]        act_mem_addr,
   output logic [DATA_WIDTH-1:0]        act_mem_wdata,
   input  logic                         clr_p,
   output logic [WR_COUNT_W-1:0]        wr_count,
   output logic                         idle,
   output logic                         req_drop_err
);

   logic [NUM_CH-1:0]     eligible;
   logic [NUM_CH-1:0]     arb_gnt;
   logic [RR_IDX_W-1:0]   arb_idx;
   logic                  arb_vld;
   logic                  grant;
   logic                  drop_det;

   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [NUM_CH-1:0]     ack_q, ack_d;
   logic [RR_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [WR_COUNT_W-1:0] wr_count_q, wr_count_d;
   logic                  drop_err_q, drop_err_d;
   logic [NUM_CH-1:0]     wr_prev_q, wr_prev_d;
   logic [NUM_CH-1:0]     ack_prev_q, ack_prev_d;

   // A channel acked this cycle still shows its request; it drops it next cycle.
   assign eligible = hw_mem_wr & ~ack_q;

   npu_rr_arbiter u_rr_arbiter (
      .req     (eligible),
      .ptr     (rr_ptr_q),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .gnt_vld (arb_vld)
   );

   always_comb begin
      grant    = act_mem_ready & arb_vld;
      we_d     = grant;
      ack_d    = grant ? arb_gnt : '0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rr_ptr_d = rr_ptr_q;
      if (grant) begin
         addr_d   = hw_mem_wr_addr[ADDR_WIDTH*arb_idx +: ADDR_WIDTH];
         wdata_d  = hw_mem_wr_data[DATA_WIDTH*arb_idx +: DATA_WIDTH];
         rr_ptr_d = next_ptr(arb_idx);
      end
   end

   always_comb begin
      wr_count_d = wr_count_q;
      if (clr_p) begin
         wr_count_d = '0;
      end else if (we_q && (wr_count_q != WR_COUNT_MAX)) begin
         wr_count_d = wr_count_q + WR_COUNT_W'(1);
      end
      // A request that falls without a preceding ack was abandoned by its neuron.
      drop_det   = |(wr_prev_q & ~hw_mem_wr & ~ack_prev_q);
      drop_err_d = drop_det | (drop_err_q & ~clr_p);
      wr_prev_d  = hw_mem_wr;
      ack_prev_d = ack_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         ack_q      <= '0;
         rr_ptr_q   <= '0;
         wr_count_q <= '0;
         drop_err_q <= 1'b0;
         wr_prev_q  <= '0;
         ack_prev_q <= '0;
      end else begin
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         ack_q      <= ack_d;
         rr_ptr_q   <= rr_ptr_d;
         wr_count_q <= wr_count_d;
         drop_err_q <= drop_err_d;
         wr_prev_q  <= wr_prev_d;
         ack_prev_q <= ack_prev_d;
      end
   end

   assign act_mem_we      = we_q;
   assign act_mem_addr    = addr_q;
   assign act_mem_wdata   = wdata_q;
   assign hw_mem_wr_ack_p = ack_q;
   assign wr_count        = wr_count_q;
   assign req_drop_err    = drop_err_q;
   assign idle            = ~|eligible & ~we_q;

endmodule
